// File: rtl/sbox_share_compress_pkg.sv
// Shared constants, lane typedef and slice helpers for the masked Midori
// S-box share compression stage.
package sbox_share_compress_pkg;

    localparam int CF_BITS = 27;
    localparam int SHARES  = 3;
    localparam int SBOX_W  = 3;

    // One compressed S-box result: SHARES shares of SBOX_W bits, index [share][bit].
    typedef logic [SHARES-1:0][SBOX_W-1:0] lane_t;

    // LSB position of a lane inside a packed share word.
    function automatic int lane_lsb(input int lane);
        return SBOX_W * lane;
    endfunction

    // First component-function bit feeding output bit j of share k.
    function automatic int cf_base(input int k, input int j);
        return (SBOX_W * SBOX_W) * k + SBOX_W * j;
    endfunction

endpackage

// File: rtl/sbox_share_compress_cf_compress.sv
// Purely combinational 27 -> 3x3 XOR tree. Every output bit folds one triple
// of component functions that all belong to the same share; no term from
// another share ever enters the tree.
module sbox_share_compress_cf_compress
    import sbox_share_compress_pkg::*;
(
    input  logic [CF_BITS-1:0] cf_q,
    output lane_t              shares
);

    // Fold each same-share triple of component-function outputs into one bit.
    always_comb begin
        shares = {(SHARES*SBOX_W){1'b0}};
        for (int k = 0; k < SHARES; k++) begin
            for (int j = 0; j < SBOX_W; j++) begin
                shares[k][j] = cf_q[cf_base(k, j)]
                             ^ cf_q[cf_base(k, j) + 1]
                             ^ cf_q[cf_base(k, j) + 2];
            end
        end
    end

endmodule

// File: rtl/sbox_share_compress.sv
// sbox_share_compress: glitch-barrier register on the component-function bits,
// share-wise XOR compression, and packing of NSBOX lanes into one three-share
// word delivered with valid/ready.
// Optional build macro: SBOX_CF_FLUSH_EN zeroes cf_q after consumption and
// the pack buffer after a completing write. Handshake timing is unchanged.
module sbox_share_compress
    import sbox_share_compress_pkg::*;
#(
    parameter int NSBOX = 16
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CF_BITS-1:0]         cf_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [SBOX_W*NSBOX-1:0]    share0,
    output logic [SBOX_W*NSBOX-1:0]    share1,
    output logic [SBOX_W*NSBOX-1:0]    share2
);

    localparam int                WORD_W   = SBOX_W * NSBOX;
    localparam int                IDX_W    = $clog2(NSBOX);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NSBOX - 1);

    typedef logic [SHARES-1:0][WORD_W-1:0] word_t;

    logic [CF_BITS-1:0] cf_q_r;
    logic               v1_r;
    logic [IDX_W-1:0]   idx_r;
    word_t              pack_r;
    word_t              out_r;
    logic               out_valid_r;

    lane_t              lane_s;
    word_t              word_s;
    logic               last_s;
    logic               write_s;
    logic               complete_s;
    logic               in_ready_s;
    logic               load_s;

    // Compression sees only the barrier register, never the raw input.
    sbox_share_compress_cf_compress u_cf_compress (
        .cf_q   (cf_q_r),
        .shares (lane_s)
    );

    // Handshake decode: the completing write is the only one that waits on the consumer.
    always_comb begin
        last_s     = (idx_r == LAST_IDX);
        write_s    = v1_r && (!last_s || !out_valid_r || out_ready);
        complete_s = write_s && last_s;
        in_ready_s = !v1_r || write_s;
        load_s     = in_valid && in_ready_s;
    end

    // Pack buffer with the current lane merged in at slot idx.
    always_comb begin
        word_s = pack_r;
        for (int k = 0; k < SHARES; k++) begin
            word_s[k][lane_lsb(int'(idx_r)) +: SBOX_W] = lane_s[k];
        end
    end

    // Glitch-barrier register and its valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cf_q_r <= {CF_BITS{1'b0}};
            v1_r   <= 1'b0;
        end else if (load_s) begin
            cf_q_r <= cf_in;
            v1_r   <= 1'b1;
        end else if (write_s) begin
`ifdef SBOX_CF_FLUSH_EN
            cf_q_r <= {CF_BITS{1'b0}};
`endif
            v1_r   <= 1'b0;
        end
    end

    // Lane counter and pack buffer; lanes fill strictly in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r  <= {IDX_W{1'b0}};
            pack_r <= {(SHARES*WORD_W){1'b0}};
        end else if (complete_s) begin
            idx_r  <= {IDX_W{1'b0}};
`ifdef SBOX_CF_FLUSH_EN
            pack_r <= {(SHARES*WORD_W){1'b0}};
`endif
        end else if (write_s) begin
            idx_r  <= idx_r + IDX_W'(1);
            pack_r <= word_s;
        end
    end

    // Output word register; only a completing write changes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r <= {(SHARES*WORD_W){1'b0}};
        end else if (complete_s) begin
            out_r <= word_s;
        end
    end

    // Output valid: a completing write wins over a same-cycle handshake, so no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
        end else if (complete_s) begin
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign share0    = out_r[0];
    assign share1    = out_r[1];
    assign share2    = out_r[2];

endmodule

// File: tb/tb_sbox_share_compress.sv
// Self-checking bench for sbox_share_compress (NSBOX = 16). A behavioural
// model packs accepted inputs into expected words, compares them at each
// output handshake, and checks directed handshake and reset scenarios.
module tb_sbox_share_compress;

    localparam int NSBOX = 16;
    localparam int WW    = 3 * NSBOX;

    logic          clk;
    logic          rst;
    logic [26:0]   cf_in;
    logic          in_valid;
    logic          in_ready;
    logic          out_ready;
    logic          out_valid;
    logic [WW-1:0] share0;
    logic [WW-1:0] share1;
    logic [WW-1:0] share2;

    sbox_share_compress #(.NSBOX(NSBOX)) dut (
        .clk       (clk),
        .rst       (rst),
        .cf_in     (cf_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .share0    (share0),
        .share1    (share1),
        .share2    (share2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WW-1:0] s0;
        logic [WW-1:0] s1;
        logic [WW-1:0] s2;
    } word_t;

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_accept = 0;
    int            model_n  = 0;
    word_t         cur_w;
    word_t         exp_words[$];
    logic          prev_hold = 1'b0;
    logic [WW-1:0] prev_s0, prev_s1, prev_s2;
    logic [26:0]   last_cf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Share k bit j is the parity of component functions 9k+3j .. 9k+3j+2.
    function automatic logic [8:0] ref_lane(input logic [26:0] cf);
        logic [8:0]  r;
        logic [26:0] tri_bits;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                tri_bits     = (cf >> (9 * k + 3 * j)) & 27'h7;
                r[3 * k + j] = 1'($countones(tri_bits) % 2);
            end
        end
        return r;
    endfunction

    task automatic model_accept(input logic [26:0] cf);
        logic [8:0] l;
        l = ref_lane(cf);
        cur_w.s0[3 * model_n +: 3] = l[2:0];
        cur_w.s1[3 * model_n +: 3] = l[5:3];
        cur_w.s2[3 * model_n +: 3] = l[8:6];
        model_n++;
        if (model_n == NSBOX) begin
            exp_words.push_back(cur_w);
            cur_w   = '0;
            model_n = 0;
        end
    endtask

    // One clock cycle: drive, sample before the edge, advance to next negedge.
    task automatic cycle(input logic iv, input logic [26:0] cf, input logic ordy);
        word_t w;
        in_valid  = iv;
        cf_in     = cf;
        out_ready = ordy;
        #1;
        if (prev_hold) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_s0", 64'(share0), 64'(prev_s0));
            chk("hold_s1", 64'(share1), 64'(prev_s1));
            chk("hold_s2", 64'(share2), 64'(prev_s2));
        end
        if (out_valid && out_ready) begin
            chk("word_avail", 64'(exp_words.size() != 0), 64'(1));
            if (exp_words.size() != 0) begin
                w = exp_words.pop_front();
                chk("word_s0", 64'(share0), 64'(w.s0));
                chk("word_s1", 64'(share1), 64'(w.s1));
                chk("word_s2", 64'(share2), 64'(w.s2));
            end
        end
        if (in_valid && in_ready) begin
            model_accept(cf);
            n_accept++;
            last_cf = cf;
        end
        prev_hold = out_valid && !out_ready;
        prev_s0   = share0;
        prev_s1   = share1;
        prev_s2   = share2;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        cf_in     = 27'($urandom);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_words.delete();
        cur_w     = '0;
        model_n   = 0;
        prev_hold = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cur_w     = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        cf_in     = 27'h0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_share0", 64'(share0), 64'(0));
        chk("rst_share1", 64'(share1), 64'(0));
        chk("rst_share2", 64'(share2), 64'(0));

        // Sixteen lanes of 27'h7: only share0 bit0 of every lane is set
        for (int i = 0; i < NSBOX; i++) cycle(1'b1, 27'h0000007, 1'b1);
        chk("t1_not_yet_valid", 64'(out_valid), 64'(0));
        cycle(1'b0, 27'h0, 1'b1);
        chk("t1_valid", 64'(out_valid), 64'(1));
        chk("t1_share0", 64'(share0), 64'h249249249249);
        chk("t1_share1", 64'(share1), 64'(0));
        chk("t1_share2", 64'(share2), 64'(0));
        cycle(1'b0, 27'h0, 1'b1);

        // All-ones in lane 5 only: all nine output bits of that lane set, nothing else
        for (int i = 0; i < NSBOX; i++) cycle(1'b1, (i == 5) ? 27'h7FFFFFF : 27'h0, 1'b1);
        cycle(1'b0, 27'h0, 1'b0);
        chk("t2_valid", 64'(out_valid), 64'(1));
        chk("t2_share0", 64'(share0), 64'h38000);
        chk("t2_share1", 64'(share1), 64'h38000);
        chk("t2_share2", 64'(share2), 64'h38000);
        cycle(1'b0, 27'h0, 1'b1);
        chk("t2_drained", 64'(exp_words.size()), 64'(0));

        // Back-pressure: second word fills, completing write stalls
        n_accept = 0;
        for (int i = 0; i < 40; i++) cycle(1'b1, 27'($urandom), 1'b0);
        chk("stall_accepts", 64'(n_accept), 64'(2 * NSBOX));
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        chk("stall_out_valid", 64'(out_valid), 64'(1));
        cycle(1'b1, 27'($urandom), 1'b1);
        chk("swap_valid", 64'(out_valid), 64'(1));
        chk("swap_pending", 64'(exp_words.size()), 64'(1));
        if (exp_words.size() != 0) begin
            chk("swap_s0", 64'(share0), 64'(exp_words[0].s0));
            chk("swap_s1", 64'(share1), 64'(exp_words[0].s1));
            chk("swap_s2", 64'(share2), 64'(exp_words[0].s2));
        end
        cycle(1'b0, 27'h0, 1'b1);

        // in_valid toggled every other cycle, then fully random traffic
        for (int i = 0; i < 64; i++) cycle(1'((i % 2) == 0), 27'($urandom), 1'b1);
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 27'($urandom), 1'($urandom_range(0, 3) != 0));
        for (int b = 0; b < 40 && model_n != 0; b++) cycle(1'b1, 27'($urandom), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 27'h0, 1'b1);
        chk("random_drained", 64'(exp_words.size()), 64'(0));
        chk("random_lane_align", 64'(model_n), 64'(0));

        // Reset mid-word with a lane waiting in the barrier
        for (int i = 0; i < 8; i++) cycle(1'b1, 27'($urandom), 1'b1);
        do_reset();
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_share0", 64'(share0), 64'(0));
        chk("mid_rst_share1", 64'(share1), 64'(0));
        chk("mid_rst_share2", 64'(share2), 64'(0));
        for (int i = 0; i < NSBOX; i++) cycle(1'b1, 27'($urandom), 1'b1);
        cycle(1'b0, 27'h0, 1'b1);
        chk("post_rst_valid", 64'(out_valid), 64'(1));
`ifdef SBOX_CF_FLUSH_EN
        chk("cf_q_flushed", 64'(dut.cf_q_r), 64'(0));
        chk("pack_flushed0", 64'(dut.pack_r[0]), 64'(0));
        chk("pack_flushed1", 64'(dut.pack_r[1]), 64'(0));
        chk("pack_flushed2", 64'(dut.pack_r[2]), 64'(0));
`else
        chk("cf_q_retained", 64'(dut.cf_q_r), 64'(last_cf));
`endif
        cycle(1'b0, 27'h0, 1'b1);
        chk("post_rst_drained", 64'(exp_words.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
